// File: rtl/cobra_tb_pkg.sv
// Shared types and constants for the CYBERcobra stimulus/response checker.
package cobra_tb_pkg;

    // Default geometry of the vector table.
    localparam int SW_W_D    = 16;
    localparam int OUT_W_D   = 32;
    localparam int NUM_VEC_D = 8;

    // Sequencer state encoding.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_DUT_RST = 2'd1;
    localparam state_t ST_WAIT    = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    // One table entry at default widths: switch stimulus and expected core output.
    typedef struct packed {
        logic [SW_W_D-1:0]  sw;
        logic [OUT_W_D-1:0] exp;
    } vec_t;

    // Bits needed to hold values 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_D = idx_w(NUM_VEC_D);

endpackage

// File: rtl/cobra_vec_table.sv
// Vector table: NUM_VEC entries of {sw, exp}, one synchronous write port and
// one combinational read port. Contents are deliberately not reset so a table
// loaded once survives a checker reset.
module cobra_vec_table
    import cobra_tb_pkg::*;
#(
    parameter int SW_W    = 16,
    parameter int OUT_W   = 32,
    parameter int NUM_VEC = 8,
    parameter int IDX_W   = idx_w(NUM_VEC)
)(
    input  logic             clk_i,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [SW_W-1:0]  wsw,
    input  logic [OUT_W-1:0] wexp,
    input  logic [IDX_W-1:0] raddr,
    output logic [SW_W-1:0]  rsw,
    output logic [OUT_W-1:0] rexp
);

    logic [SW_W+OUT_W-1:0] mem [NUM_VEC];

    // Table write; the caller already blocks writes during a run.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= {wsw, wexp};
        end
    end

    assign rsw  = mem[raddr][SW_W+OUT_W-1:OUT_W];
    assign rexp = mem[raddr][OUT_W-1:0];

endmodule

// File: rtl/cobra_stim_checker.sv
// Stimulus/response sequencer for the CYBERcobra core: per vector, resets the
// core, drives sw, and waits for out to match and hold, or for a timeout.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | after reset, core held in reset, waiting for start
// ST_DUT_RST | core reset asserted for RST_CYC cycles with sw applied
// ST_WAIT    | core running, counting matching cycles and the timeout
// ST_DONE    | run finished, pass/fail and counters held until next start
module cobra_stim_checker
    import cobra_tb_pkg::*;
#(
    parameter  int SW_W       = 16,
    parameter  int OUT_W      = 32,
    parameter  int NUM_VEC    = 8,
    parameter  int RST_CYC    = 2,
    parameter  int STABLE_CYC = 4,
    parameter  int TIMEOUT    = 1024,
    parameter  int CNT_W      = 24,
    localparam int IDX_W      = idx_w(NUM_VEC)
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_addr_i,
    input  logic [SW_W-1:0]  cfg_sw_i,
    input  logic [OUT_W-1:0] cfg_exp_i,
    input  logic [IDX_W:0]   cfg_cnt_i,
    output logic             dut_rst_o,
    output logic [SW_W-1:0]  dut_sw_o,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [IDX_W-1:0] fail_idx_o,
    output logic [OUT_W-1:0] fail_val_o,
    output logic [CNT_W-1:0] cyc_cnt_o
);

    // Timers are down-counters loaded with (length-1) and finish at zero.
    localparam int RC_W = idx_w(RST_CYC);
    localparam int TM_W = idx_w(TIMEOUT);
    localparam int ST_W = idx_w(STABLE_CYC);

    localparam logic [RC_W-1:0]  RST_LOAD   = RC_W'(RST_CYC - 1);
    localparam logic [TM_W-1:0]  TMR_LOAD   = TM_W'(TIMEOUT - 1);
    localparam logic [ST_W-1:0]  STABLE_TOP = ST_W'(STABLE_CYC - 1);
    localparam logic [IDX_W:0]   CNT_MAX    = (IDX_W+1)'(NUM_VEC);
    localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);
    localparam logic [CNT_W-1:0] CYC_ONE    = CNT_W'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   cnt;
    logic [RC_W-1:0]  rst_tmr;
    logic [TM_W-1:0]  wait_tmr;
    logic [ST_W-1:0]  stable;
    logic             pass_q;
    logic             fail_q;
    logic [IDX_W-1:0] fail_idx_q;
    logic [OUT_W-1:0] fail_val_q;
    logic [CNT_W-1:0] cyc_q;

    logic [SW_W-1:0]  tab_sw;
    logic [OUT_W-1:0] tab_exp;
    logic             busy;
    logic             match;
    logic             pass_hit;
    logic             last_vec;
    logic [IDX_W:0]   cnt_clamped;
    logic [CNT_W-1:0] cyc_inc;

    cobra_vec_table #(
        .SW_W    (SW_W),
        .OUT_W   (OUT_W),
        .NUM_VEC (NUM_VEC),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk_i (clk_i),
        .we    (cfg_we_i && !busy),
        .waddr (cfg_addr_i),
        .wsw   (cfg_sw_i),
        .wexp  (cfg_exp_i),
        .raddr (idx),
        .rsw   (tab_sw),
        .rexp  (tab_exp)
    );

    assign busy        = (state == ST_DUT_RST) || (state == ST_WAIT);
    assign match       = (dut_out_i == tab_exp);
    assign pass_hit    = match && (stable == STABLE_TOP);
    assign last_vec    = ({1'b0, idx} == (cnt - CNT_ONE));
    assign cnt_clamped = (cfg_cnt_i > CNT_MAX) ? CNT_MAX : cfg_cnt_i;
    assign cyc_inc     = (cyc_q == {CNT_W{1'b1}}) ? cyc_q : (cyc_q + CYC_ONE);

    // Sequencer FSM with its vector index, timers and result registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            rst_tmr    <= '0;
            wait_tmr   <= '0;
            stable     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
            fail_val_q <= '0;
            cyc_q      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        // The start cycle itself counts toward the run length.
                        cyc_q      <= CYC_ONE;
                        fail_q     <= 1'b0;
                        fail_idx_q <= '0;
                        fail_val_q <= '0;
                        idx        <= '0;
                        if (cfg_cnt_i == '0) begin
                            pass_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            pass_q  <= 1'b0;
                            cnt     <= cnt_clamped;
                            rst_tmr <= RST_LOAD;
                            state   <= ST_DUT_RST;
                        end
                    end
                end
                ST_DUT_RST: begin
                    cyc_q <= cyc_inc;
                    if (abort_i) begin
                        fail_q     <= 1'b1;
                        fail_idx_q <= idx;
                        fail_val_q <= dut_out_i;
                        state      <= ST_DONE;
                    end else if (rst_tmr == '0) begin
                        stable   <= '0;
                        wait_tmr <= TMR_LOAD;
                        state    <= ST_WAIT;
                    end else begin
                        rst_tmr <= rst_tmr - 1'b1;
                    end
                end
                ST_WAIT: begin
                    cyc_q <= cyc_inc;
                    // Abort beats pass, and pass beats timeout, in one cycle.
                    if (abort_i) begin
                        fail_q     <= 1'b1;
                        fail_idx_q <= idx;
                        fail_val_q <= dut_out_i;
                        state      <= ST_DONE;
                    end else if (pass_hit) begin
                        if (last_vec) begin
                            pass_q <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            rst_tmr <= RST_LOAD;
                            state   <= ST_DUT_RST;
                        end
                    end else if (wait_tmr == '0) begin
                        fail_q     <= 1'b1;
                        fail_idx_q <= idx;
                        fail_val_q <= dut_out_i;
                        state      <= ST_DONE;
                    end else begin
                        wait_tmr <= wait_tmr - 1'b1;
                        stable   <= match ? (stable + 1'b1) : '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The core only runs in WAIT; everywhere else it is held in reset.
    assign dut_rst_o  = (state != ST_WAIT);
    assign dut_sw_o   = busy ? tab_sw : '0;
    assign busy_o     = busy;
    assign done_o     = (state == ST_DONE);
    assign pass_o     = pass_q;
    assign fail_o     = fail_q;
    assign fail_idx_o = fail_idx_q;
    assign fail_val_o = fail_val_q;
    assign cyc_cnt_o  = cyc_q;

endmodule

// File: tb/tb_cobra_stim_checker.sv
// Self-checking bench for cobra_stim_checker with a behavioural core model.
module tb_cobra_stim_checker;
    import cobra_tb_pkg::*;

    localparam int NV  = 8;
    localparam int RST = 2;
    localparam int STB = 4;
    localparam int TO  = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_sw;
    logic [31:0] cfg_exp;
    logic [3:0]  cfg_cnt;

    logic        a_rst, a_busy, a_done, a_pass, a_fail;
    logic [15:0] a_sw;
    logic [31:0] a_out, a_val;
    logic [2:0]  a_idx;
    logic [23:0] a_cyc;

    logic        b_rst, b_busy, b_done, b_pass, b_fail;
    logic [15:0] b_sw;
    logic [31:0] b_out, b_val;
    logic [2:0]  b_idx;
    logic [23:0] b_cyc;

    int core_mode = 0;
    int core_ka   = 0;
    int core_kb   = 0;
    int wait_cnt  = 0;
    int n_tests   = 0;
    int n_fail    = 0;

    vec_t tb_tab [NV];

    always #5 clk = ~clk;

    // Core behaviour as a function of cycles since reset release (k):
    // mode 0: out = zero-extended sw; mode 1: 5/6 alternating every 3 cycles;
    // mode 2: garbage for sw[2:0] cycles, then zero-extended sw.
    function automatic logic [31:0] core_out(input int mode, input logic [15:0] sw, input int k);
        case (mode)
            1:       return (((k / 3) % 2) == 0) ? 32'h5 : 32'h6;
            2:       return (k < int'(sw[2:0])) ? (32'hDEAD0000 | {16'h0, sw}) : {16'h0, sw};
            default: return {16'h0, sw};
        endcase
    endfunction

    always @(posedge clk) core_ka <= a_rst ? 0 : core_ka + 1;
    always @(posedge clk) core_kb <= b_rst ? 0 : core_kb + 1;
    always @(negedge clk) if (!a_rst) wait_cnt <= wait_cnt + 1;

    assign a_out = core_out(core_mode, a_sw, core_ka);
    assign b_out = core_out(core_mode, b_sw, core_kb);

    cobra_stim_checker #(
        .SW_W(16), .OUT_W(32), .NUM_VEC(NV), .RST_CYC(RST),
        .STABLE_CYC(STB), .TIMEOUT(TO), .CNT_W(24)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .abort_i(abort),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_sw_i(cfg_sw),
        .cfg_exp_i(cfg_exp), .cfg_cnt_i(cfg_cnt),
        .dut_rst_o(a_rst), .dut_sw_o(a_sw), .dut_out_i(a_out),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .fail_o(a_fail),
        .fail_idx_o(a_idx), .fail_val_o(a_val), .cyc_cnt_o(a_cyc)
    );

    cobra_stim_checker #(
        .SW_W(16), .OUT_W(32), .NUM_VEC(NV), .RST_CYC(RST),
        .STABLE_CYC(3), .TIMEOUT(TO), .CNT_W(24)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .abort_i(abort),
        .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_sw_i(cfg_sw),
        .cfg_exp_i(cfg_exp), .cfg_cnt_i(cfg_cnt),
        .dut_rst_o(b_rst), .dut_sw_o(b_sw), .dut_out_i(b_out),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass), .fail_o(b_fail),
        .fail_idx_o(b_idx), .fail_val_o(b_val), .cyc_cnt_o(b_cyc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] s, input logic [31:0] e);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_sw = s; cfg_exp = e;
        @(negedge clk);
        cfg_we = 1'b0;
        tb_tab[a] = '{sw: s, exp: e};
    endtask

    task automatic do_run(input logic [3:0] cnt, input int limit, output bit ok);
        @(negedge clk);
        cfg_cnt = cnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < limit && a_done !== 1'b1; n++) @(negedge clk);
        ok = (a_done === 1'b1);
    endtask

    // Reference: walk each vector, find the first wait cycle where the match
    // run reaches STB, otherwise the vector times out after TO wait cycles.
    function automatic void model(input int mode, input int cnt_in, output bit p, output bit f,
                                  output logic [2:0] idx, output logic [31:0] val, output int cyc);
        int n;
        int run;
        bit passed;
        n = (cnt_in > NV) ? NV : cnt_in;
        p = 1'b0; f = 1'b0; idx = '0; val = '0; cyc = 1;
        for (int i = 0; i < n; i++) begin
            run = 0;
            passed = 1'b0;
            for (int k = 0; k < TO && !passed; k++) begin
                run = (core_out(mode, tb_tab[i].sw, k) == tb_tab[i].exp) ? run + 1 : 0;
                if (run == STB) begin
                    passed = 1'b1;
                    cyc += RST + k + 1;
                end
            end
            if (!passed) begin
                f = 1'b1;
                idx = 3'(i);
                val = core_out(mode, tb_tab[i].sw, TO - 1);
                cyc += RST + TO;
                return;
            end
        end
        p = 1'b1;
    endfunction

    typedef struct {
        int          mode;
        logic [3:0]  cnt;
        logic [15:0] sw0;
        logic [31:0] exp0;
        logic [15:0] sw1;
        logic [31:0] exp1;
        bit          e_pass;
        bit          e_fail;
        logic [2:0]  e_idx;
        logic [31:0] e_val;
        int          e_cyc;
    } dvec_t;

    dvec_t dir [6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          mp, mf;
        logic [2:0]  midx;
        logic [31:0] mval;
        int          mcyc;
        int          w0;
        int          mode;
        int          cnt;

        dir[0] = '{0, 4'd2, 16'hBCC3, 32'h0000BCC3, 16'h0108, 32'h00000108, 1'b1, 1'b0, 3'd0, 32'h0,   13};
        dir[1] = '{0, 4'd2, 16'hBCC3, 32'h0000BCC3, 16'h0108, 32'h00000109, 1'b0, 1'b1, 3'd1, 32'h108, 1033};
        dir[2] = '{2, 4'd1, 16'h0003, 32'h00000003, 16'h0108, 32'h00000108, 1'b1, 1'b0, 3'd0, 32'h0,   10};
        dir[3] = '{1, 4'd1, 16'h0000, 32'h00000005, 16'h0000, 32'h00000005, 1'b0, 1'b1, 3'd0, 32'h6,   1027};
        dir[4] = '{0, 4'd0, 16'h1234, 32'h00001234, 16'h0000, 32'h00000000, 1'b1, 1'b0, 3'd0, 32'h0,   1};
        dir[5] = '{2, 4'd2, 16'h0005, 32'h00000005, 16'h0002, 32'h00000002, 1'b1, 1'b0, 3'd0, 32'h0,   20};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_sw = '0; cfg_exp = '0; cfg_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst_dut_rst", 64'(a_rst), 64'd1);
        chk("rst_busy",    64'(a_busy), 64'd0);
        chk("rst_done",    64'(a_done), 64'd0);
        chk("rst_pass",    64'(a_pass), 64'd0);
        chk("rst_fail",    64'(a_fail), 64'd0);
        chk("rst_cyc",     64'(a_cyc), 64'd0);
        chk("rst_sw",      64'(a_sw), 64'd0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            core_mode = dir[i].mode;
            wr(3'd0, dir[i].sw0, dir[i].exp0);
            wr(3'd1, dir[i].sw1, dir[i].exp1);
            w0 = wait_cnt;
            do_run(dir[i].cnt, 20000, ok);
            chk($sformatf("dir%0d_done", i), 64'(ok), 64'd1);
            chk($sformatf("dir%0d_busy", i), 64'(a_busy), 64'd0);
            chk($sformatf("dir%0d_pass", i), 64'(a_pass), 64'(dir[i].e_pass));
            chk($sformatf("dir%0d_fail", i), 64'(a_fail), 64'(dir[i].e_fail));
            chk($sformatf("dir%0d_idx", i),  64'(a_idx), 64'(dir[i].e_idx));
            chk($sformatf("dir%0d_val", i),  64'(a_val), 64'(dir[i].e_val));
            chk($sformatf("dir%0d_cyc", i),  64'(a_cyc), 64'(dir[i].e_cyc));
            chk($sformatf("dir%0d_rst_release", i), 64'(wait_cnt != w0), 64'(dir[i].cnt != 4'd0));
            if (dir[i].mode == 1) begin
                chk("stable3_pass", 64'(b_pass), 64'd1);
                chk("stable3_fail", 64'(b_fail), 64'd0);
                chk("stable3_cyc",  64'(b_cyc), 64'd6);
            end
        end

        // Count above NUM_VEC clamps to the full table.
        core_mode = 0;
        for (int i = 0; i < NV; i++) wr(3'(i), 16'(i * 16'h1111 + 16'h0100), 32'(i * 16'h1111 + 16'h0100));
        do_run(4'd15, 20000, ok);
        chk("clamp_done", 64'(ok), 64'd1);
        chk("clamp_pass", 64'(a_pass), 64'd1);
        chk("clamp_cyc",  64'(a_cyc), 64'd49);

        // Abort in WAIT of vector 0, with a table write attempted while busy.
        wr(3'd0, 16'h0010, 32'h00000010);
        wr(3'd1, 16'h00F0, 32'h000000F1);
        @(negedge clk);
        cfg_cnt = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat_busy",    64'(a_busy), 64'd1);
        chk("lat_dut_rst", 64'(a_rst), 64'd1);
        chk("lat_sw",      64'(a_sw), 64'h0010);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_sw = 16'h0010; cfg_exp = 32'h00000011;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("lat_rst_hold", 64'(a_rst), 64'd1);
        @(negedge clk);
        chk("lat_rst_fall", 64'(a_rst), 64'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", 64'(a_done), 64'd1);
        chk("abort_fail", 64'(a_fail), 64'd1);
        chk("abort_pass", 64'(a_pass), 64'd0);
        chk("abort_idx",  64'(a_idx), 64'd0);
        chk("abort_val",  64'(a_val), 64'h10);
        chk("abort_cyc",  64'(a_cyc), 64'd4);
        do_run(4'd1, 20000, ok);
        chk("busy_write_ignored_pass", 64'(a_pass), 64'd1);
        chk("busy_write_ignored_cyc",  64'(a_cyc), 64'd7);

        // Reset during WAIT.
        wr(3'd0, 16'h00F0, 32'h000000F1);
        @(negedge clk);
        cfg_cnt = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50 && a_rst !== 1'b0; n++) @(negedge clk);
        chk("midrst_reached_wait", 64'(a_rst), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_dut_rst", 64'(a_rst), 64'd1);
        chk("midrst_busy",    64'(a_busy), 64'd0);
        chk("midrst_done",    64'(a_done), 64'd0);
        chk("midrst_fail",    64'(a_fail), 64'd0);
        chk("midrst_pass",    64'(a_pass), 64'd0);
        chk("midrst_val",     64'(a_val), 64'd0);
        chk("midrst_cyc",     64'(a_cyc), 64'd0);
        wr(3'd0, 16'h0010, 32'h00000010);
        do_run(4'd1, 20000, ok);
        chk("midrst_rerun_pass", 64'(a_pass), 64'd1);
        chk("midrst_rerun_cyc",  64'(a_cyc), 64'd7);

        // Randomized runs against the reference model.
        for (int r = 0; r < 12; r++) begin
            mode = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 1) == 0) ? 0 : 2);
            core_mode = mode;
            for (int i = 0; i < NV; i++) begin
                logic [15:0] s;
                logic [31:0] e;
                s = 16'($urandom);
                e = {16'h0, s};
                if (mode == 1 && $urandom_range(0, 1) == 0) e = 32'h5;
                else if ($urandom_range(0, 9) == 0) e = e ^ (32'h1 << $urandom_range(0, 31));
                wr(3'(i), s, e);
            end
            cnt = $urandom_range(0, 10);
            model(mode, cnt, mp, mf, midx, mval, mcyc);
            do_run(4'(cnt), 20000, ok);
            chk($sformatf("rnd%0d_done", r), 64'(ok), 64'd1);
            chk($sformatf("rnd%0d_pass", r), 64'(a_pass), 64'(mp));
            chk($sformatf("rnd%0d_fail", r), 64'(a_fail), 64'(mf));
            chk($sformatf("rnd%0d_idx", r),  64'(a_idx), 64'(midx));
            chk($sformatf("rnd%0d_val", r),  64'(a_val), 64'(mval));
            chk($sformatf("rnd%0d_cyc", r),  64'(a_cyc), 64'(mcyc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cobra_stim_checker.md
Name: cobra_stim_checker

Overview:
- Synthesizable, self-checking stimulus/response sequencer for the CYBERcobra-class core.
- Holds a table of up to NUM_VEC switch vectors with expected outputs.
- For each vector it resets the core, drives its sw_i input, and waits until out_o equals the expected value and holds it for STABLE_CYC cycles, or until a timeout.
- Reports pass/fail, the failing index and value, and the total cycle count. Usable on board (Nexys A7) and in simulation.

Parameters:
- SW_W, 16: switch vector width.
- OUT_W, 32: core output width.
- NUM_VEC, 8: vector table depth (power of 2, >=2).
- RST_CYC, 2: cycles the core reset is held per vector (>=1).
- STABLE_CYC, 4: consecutive matching cycles required for a pass (>=1).
- TIMEOUT, 1024: maximum wait cycles per vector after core reset release.
- CNT_W, 24: width of the total cycle counter.

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: synchronous, active-low reset.
- start_i, in, 1: run request, sampled in IDLE or DONE.
- abort_i, in, 1: stop run, honoured only while busy.
- cfg_we_i, in, 1: table write strobe, ignored while busy.
- cfg_addr_i, in, IDX_W=$clog2(NUM_VEC): table write address.
- cfg_sw_i, in, SW_W: vector switch value.
- cfg_exp_i, in, OUT_W: vector expected output.
- cfg_cnt_i, in, IDX_W+1: number of vectors to run, sampled at start.
- dut_rst_o, out, 1: active-high reset to the core.
- dut_sw_o, out, SW_W: drives the core sw_i.
- dut_out_i, in, OUT_W: core out_o.
- busy_o, out, 1: run in progress.
- done_o, out, 1: run finished; held until the next start.
- pass_o, out, 1: all vectors matched.
- fail_o, out, 1: timeout or abort.
- fail_idx_o, out, IDX_W: failing vector index.
- fail_val_o, out, OUT_W: dut_out_i sampled at the failure.
- cyc_cnt_o, out, CNT_W: cycles from start to done, saturating.

Behaviour:
- Reset (rst_i=0 at clk edge):
  - State goes to IDLE.
  - dut_rst_o=1; dut_sw_o, busy_o, done_o, pass_o, fail_o, fail_idx_o, fail_val_o, cyc_cnt_o are 0.
  - Table contents are not reset.
  - Reset mid-run aborts silently, with no fail flag.
- Table: synchronous write on cfg_we_i && !busy_o. Read is combinational from the index register.
- States: IDLE, DUT_RST, WAIT, DONE.
- IDLE or DONE:
  - start_i with cfg_cnt_i==0: go to DONE next cycle with pass_o=1 and cyc_cnt_o=1.
  - start_i with cfg_cnt_i>NUM_VEC: clamp to NUM_VEC.
  - Otherwise:
    - Latch the count and set idx=0.
    - Clear pass, fail, fail_idx, fail_val and cyc_cnt.
    - Go to DUT_RST.
  - dut_rst_o stays 1 in IDLE and DONE.
- DUT_RST:
  - dut_rst_o=1, dut_sw_o=table[idx].sw, busy_o=1.
  - After exactly RST_CYC cycles go to WAIT; clear the stable and timer counters.
- WAIT:
  - dut_rst_o=0, dut_sw_o=table[idx].sw held.
  - Each cycle:
    - stable = (dut_out_i==exp) ? stable+1 : 0.
    - timer increments.
  - stable reaching STABLE_CYC means the vector passed:
    - if idx==count-1, go to DONE with pass_o=1;
    - else idx+1 and go to DUT_RST.
  - timer reaching TIMEOUT without a pass: go to DONE with fail_o=1, fail_idx_o=idx, fail_val_o=dut_out_i of that cycle.
  - If pass and timeout occur in the same cycle, pass wins.
- abort_i in DUT_RST or WAIT:
  - Go to DONE with fail_o=1, fail_idx_o=idx, fail_val_o=dut_out_i.
  - abort_i has priority over pass and timeout in the same cycle.
- Latency:
  - start_i seen at edge t gives dut_rst_o already 1 and busy_o=1 from t+1.
  - dut_rst_o falls at t+1+RST_CYC.
  - Minimum per-vector time is RST_CYC+STABLE_CYC cycles.
- cyc_cnt_o counts every busy cycle plus the final transition cycle, and saturates at all-ones.
- done_o=1 and busy_o=0 in DONE.
- pass_o and fail_o are mutually exclusive and hold until the next accepted start.
- Comparison width is exactly OUT_W bits, with no sign extension.

Decomposition:
- Package cobra_tb_pkg:
  - state enum: IDLE, DUT_RST, WAIT, DONE;
  - vec_t struct {sw, exp};
  - localparam IDX_W helper.
- One sub-module, cobra_vec_table: NUM_VEC x (SW_W+OUT_W) register file with one sync write and one async read.
- Counters and the FSM live in the top module.

Test Plan:
- Behavioural core where out = sw zero-extended after reset release. Two vectors {0xBCC3→0x0000BCC3, 0x0108→0x00000108}, defaults → pass_o=1, done_o=1, cyc_cnt_o=2*(2+4)+1=13.
- Same core, vector 1 expects 0x00000109 → fail_o=1, fail_idx_o=1, fail_val_o=0x00000108 after TIMEOUT wait cycles; pass_o=0.
- Core whose output toggles 0x5/0x6 every 3 cycles, expect 0x5, STABLE_CYC=4 → never passes, timeout fail. With STABLE_CYC=3 → pass.
- abort_i pulsed in WAIT of vector 0 → done_o next cycle, fail_o=1, fail_idx_o=0. cfg_we_i during busy leaves the table unchanged (verified by the rerun).
- start_i with cfg_cnt_i=0 → done_o=1, pass_o=1, dut_rst_o never deasserts.
- rst_i=0 in WAIT → next cycle all status outputs 0, dut_rst_o=1, IDLE; a fresh start then runs normally.
